// File: rtl/dlatch_exerciser.sv
// dlatch_exerciser: drives a D-latch under test through a fixed eight-step
// en/d vector table. Each step raises or lowers the gate first, then moves D,
// waits a settle period, and finally checks Q and Q-bar. The block counts
// failing steps and remembers the index of the first failure.
module dlatch_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       latch_q_i,
  input  logic       latch_qn_i,
  output logic       latch_d_o,
  output logic       latch_en_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_count_o,
  output logic       first_fail_valid_o,
  output logic [2:0] first_fail_step_o
);

  // Vector table, one bit per step (bit index = step index).
  //   step : 7 6 5 4 3 2 1 0
  //   en   : 1 1 0 0 1 0 0 1
  //   d    : 0 1 0 1 0 1 0 1
  //   q    : 0 1 0 0 0 1 1 1
  localparam logic [7:0] EN_TABLE = 8'b1100_1001;
  localparam logic [7:0] D_TABLE  = 8'b0101_0101;
  localparam logic [7:0] Q_TABLE  = 8'b0100_0111;

  // The settle counter is loaded with N-1 so that SETTLE lasts exactly N cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  localparam logic [2:0] LAST_STEP = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRV_EN = 3'd1,
    DRV_D  = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [3:0] settle_q, settle_d;
  logic       en_q, en_d;
  logic       d_q, d_d;
  logic [3:0] err_q, err_d;
  logic       ffv_q, ffv_d;
  logic [2:0] ffs_q, ffs_d;

  logic [2:0] stepNext;
  logic       expectedQ;
  logic       checkFail;

  // Table lookups and the pass/fail decision for the current step.
  always_comb begin
    stepNext  = step_q + 3'd1;
    expectedQ = Q_TABLE[step_q];
    checkFail = (latch_q_i != expectedQ) || (latch_qn_i == latch_q_i);
  end

  // Next-state logic: sequences the steps and accumulates the result.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    settle_d = settle_q;
    en_d     = en_q;
    d_d      = d_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffs_d    = ffs_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = DRV_EN;
          step_d   = 3'd0;
          settle_d = 4'd0;
          err_d    = 4'd0;
          ffv_d    = 1'b0;
          ffs_d    = 3'd0;
          en_d     = EN_TABLE[0];
        end
      end

      DRV_EN: begin
        // Gate has already moved; now present the new D value.
        state_d = DRV_D;
        d_d     = D_TABLE[step_q];
      end

      DRV_D: begin
        state_d  = SETTLE;
        settle_d = SETTLE_LOAD;
      end

      SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end

      CHECK: begin
        if (checkFail) begin
          err_d = err_q + 4'd1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffs_d = step_q;
          end
        end
        if (step_q == LAST_STEP) begin
          // Leave en/d at their step-7 values while results are held.
          state_d = DONE;
        end else begin
          state_d = DRV_EN;
          step_d  = stepNext;
          en_d    = EN_TABLE[stepNext];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and sequencing registers; reset abandons any run in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      step_q   <= 3'd0;
      settle_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      settle_q <= settle_d;
    end
  end

  // Registers driving the latch under test, so its inputs never glitch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      en_q <= en_d;
      d_q  <= d_d;
    end
  end

  // Result registers: error count and first-failure capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 4'd0;
      ffv_q <= 1'b0;
      ffs_q <= 3'd0;
    end else begin
      err_q <= err_d;
      ffv_q <= ffv_d;
      ffs_q <= ffs_d;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy_o = (state_q == DRV_EN) || (state_q == DRV_D) ||
             (state_q == SETTLE) || (state_q == CHECK);
    done_o = (state_q == DONE);
    pass_o = (state_q == DONE) && (err_q == 4'd0);
  end

  assign latch_en_o         = en_q;
  assign latch_d_o          = d_q;
  assign err_count_o        = err_q;
  assign first_fail_valid_o = ffv_q;
  assign first_fail_step_o  = ffs_q;

endmodule

// File: tb/tb_dlatch_exerciser.sv
// Directed testbench for dlatch_exerciser: several latch models (ideal,
// stuck, transparent buffer, broken Q-bar) plus a second instance with a
// longer settle time.
module tb_dlatch_exerciser;

  logic       clk = 1'b0;
  logic       rst;
  logic       startA, startB;
  logic       qA, qnA, dA, enA, busyA, doneA, passA, ffvA;
  logic [3:0] errA;
  logic [2:0] ffsA;
  logic       qB, qnB, dB, enB, busyB, doneB, passB, ffvB;
  logic [3:0] errB;
  logic [2:0] ffsB;

  int mode;
  int vectors = 0;
  int miscompares = 0;

  logic modelQa = 1'b0;
  logic modelQb = 1'b0;

  always #5 clk = ~clk;

  dlatch_exerciser dutA (
    .clk_i(clk), .rst_i(rst), .start_i(startA),
    .latch_q_i(qA), .latch_qn_i(qnA),
    .latch_d_o(dA), .latch_en_o(enA),
    .busy_o(busyA), .done_o(doneA), .pass_o(passA),
    .err_count_o(errA), .first_fail_valid_o(ffvA), .first_fail_step_o(ffsA)
  );

  dlatch_exerciser #(.SETTLE_CYCLES(5)) dutB (
    .clk_i(clk), .rst_i(rst), .start_i(startB),
    .latch_q_i(qB), .latch_qn_i(qnB),
    .latch_d_o(dB), .latch_en_o(enB),
    .busy_o(busyB), .done_o(doneB), .pass_o(passB),
    .err_count_o(errB), .first_fail_valid_o(ffvB), .first_fail_step_o(ffsB)
  );

  // Ideal transparent-high D latches.
  always @(enA or dA) if (enA) modelQa = dA;
  always @(enB or dB) if (enB) modelQb = dB;

  // Latch-under-test behaviour for instance A, selected by mode.
  always_comb begin
    qA  = modelQa;
    qnA = ~modelQa;
    case (mode)
      1: begin qA = 1'b0; qnA = 1'b1; end
      2: begin qA = dA;   qnA = ~dA;  end
      3: begin qA = modelQa; qnA = modelQa; end
      default: begin qA = modelQa; qnA = ~modelQa; end
    endcase
  end

  always_comb begin
    qB  = modelQb;
    qnB = ~modelQb;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " en"},   {7'd0, enA},   8'd0);
    checkOutput({tag, " d"},    {7'd0, dA},    8'd0);
    checkOutput({tag, " busy"}, {7'd0, busyA}, 8'd0);
    checkOutput({tag, " done"}, {7'd0, doneA}, 8'd0);
    checkOutput({tag, " pass"}, {7'd0, passA}, 8'd0);
    checkOutput({tag, " err"},  {4'd0, errA},  8'd0);
    checkOutput({tag, " ffv"},  {7'd0, ffvA},  8'd0);
    checkOutput({tag, " ffs"},  {5'd0, ffsA},  8'd0);
  endtask

  // One full run on instance A; optionally re-pulses start at cycle 10.
  task automatic applyStimulus(input string tag, input bit repulse,
                               input logic [3:0] expErr, input logic expFfv,
                               input logic [2:0] expFfs, input logic expPass);
    @(negedge clk) startA = 1'b1;
    @(posedge clk); #1 startA = 1'b0;
    checkOutput({tag, " busy after accept"}, {7'd0, busyA}, 8'd1);
    checkOutput({tag, " done cleared"},      {7'd0, doneA}, 8'd0);
    for (int c = 1; c <= 40; c++) begin
      if (repulse && c == 10) begin
        @(negedge clk) startA = 1'b1;
      end
      @(posedge clk); #1 startA = 1'b0;
      if (c == 39) begin
        checkOutput({tag, " done@39"}, {7'd0, doneA}, 8'd0);
        checkOutput({tag, " busy@39"}, {7'd0, busyA}, 8'd1);
      end
    end
    checkOutput({tag, " done@40"}, {7'd0, doneA}, 8'd1);
    checkOutput({tag, " busy@40"}, {7'd0, busyA}, 8'd0);
    checkOutput({tag, " pass"},    {7'd0, passA}, {7'd0, expPass});
    checkOutput({tag, " err"},     {4'd0, errA},  {4'd0, expErr});
    checkOutput({tag, " ffv"},     {7'd0, ffvA},  {7'd0, expFfv});
    checkOutput({tag, " ffs"},     {5'd0, ffsA},  {5'd0, expFfs});
    checkOutput({tag, " en hold"}, {7'd0, enA},   8'd1);
    checkOutput({tag, " d hold"},  {7'd0, dA},    8'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, " done held"}, {7'd0, doneA}, 8'd1);
    checkOutput({tag, " err held"},  {4'd0, errA},  {4'd0, expErr});
  endtask

  initial begin
    rst = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    mode = 0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);

    mode = 0;
    applyStimulus("ideal", 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
    mode = 1;
    applyStimulus("stuck", 1'b0, 4'd4, 1'b1, 3'd0, 1'b0);
    mode = 2;
    applyStimulus("buffer", 1'b0, 4'd2, 1'b1, 3'd1, 1'b0);
    mode = 3;
    applyStimulus("qn=q", 1'b0, 4'd8, 1'b1, 3'd0, 1'b0);
    mode = 0;
    applyStimulus("repulse", 1'b1, 4'd0, 1'b0, 3'd0, 1'b1);

    // Longer settle time: 8 steps of 8 cycles.
    @(negedge clk) startB = 1'b1;
    @(posedge clk); #1 startB = 1'b0;
    repeat (63) @(posedge clk);
    #1;
    checkOutput("settle5 done@63", {7'd0, doneB}, 8'd0);
    @(posedge clk); #1;
    checkOutput("settle5 done@64", {7'd0, doneB}, 8'd1);
    checkOutput("settle5 pass",    {7'd0, passB}, 8'd1);
    checkOutput("settle5 err",     {4'd0, errB},  8'd0);

    // Asynchronous reset in the middle of step 3 of a failing run.
    mode = 1;
    @(negedge clk) startA = 1'b1;
    @(posedge clk); #1 startA = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    checkOutput("midrun err before rst", {4'd0, errA}, 8'd3);
    #2 rst = 1'b1;
    #1;
    checkResetState("async rst");
    #2 rst = 1'b0;
    mode = 0;
    @(negedge clk);
    applyStimulus("after rst", 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dlatch_exerciser.md
DLATCH_EXERCISER -- requirements
Module: dlatch_exerciser

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of idle cycles between driving the latch and sampling it; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run the test sequence; sampled in IDLE or DONE only.
REQ-005 latch_q  input  1  Q output of the latch under test.
REQ-006 latch_qn  input  1  Q-bar output of the latch under test.
REQ-007 latch_d  output  1  D input driven to the latch under test.
REQ-008 latch_en  output  1  enable (gate) driven to the latch under test.
REQ-009 busy  output  1  high from the cycle after start is accepted until DONE is entered.
REQ-010 done  output  1  level; high in DONE, cleared when a new start is accepted.
REQ-011 pass  output  1  high only while done=1 and err_count=0.
REQ-012 err_count  output  4  number of failed checks in the current or last run (0..8).
REQ-013 first_fail_valid  output  1  high once any check has failed in the current run.
REQ-014 first_fail_step  output  3  step index of the first failed check; 0 while first_fail_valid=0.

Function
REQ-015 The fixed 8-step vector table (step: en,d -> expected q) is: 0: 1,1->1; 1: 0,0->1; 2: 0,1->1; 3: 1,0->0; 4: 0,1->0; 5: 0,0->0; 6: 1,1->1; 7: 1,0->0.
REQ-016 The state machine states are IDLE, DRV_EN, DRV_D, SETTLE, CHECK, DONE.
REQ-017 IDLE/DONE + start=1 -> DRV_EN with step=0, err_count=0, first_fail_valid=0, first_fail_step=0, done=0.
REQ-018 DRV_EN (1 cycle): latch_en takes the step's en value, latch_d unchanged; -> DRV_D.
REQ-019 DRV_D (1 cycle): latch_d takes the step's d value, latch_en unchanged; -> SETTLE. This ordering guarantees en falls before d changes on hold steps.
REQ-020 SETTLE: stays exactly SETTLE_CYCLES cycles using an internal down-counter; -> CHECK.
REQ-021 CHECK (1 cycle): a check fails if latch_q != expected q OR latch_qn != ~latch_q; each failing step increments err_count by exactly 1.
REQ-022 On the first failing check of a run, first_fail_valid is set and first_fail_step captures the step index; later failures do not change either.
REQ-023 CHECK with step<7 -> DRV_EN with step+1; CHECK with step=7 -> DONE.
REQ-024 Each step takes SETTLE_CYCLES+3 cycles; with default, done rises 40 cycles after the start-accept edge.
REQ-025 In DONE, latch_en and latch_d keep the step-7 values (1,0); results hold until the next accepted start.
REQ-026 start asserted while busy=1 is ignored, with no effect on step, counters or outputs.
REQ-027 latch_q/latch_qn are sampled only in CHECK; their values in all other states are ignored.

Reset
REQ-028 rst=1 forces, immediately and regardless of clk, state=IDLE, latch_en=0, latch_d=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_step=0, step=0, settle counter=0.
REQ-029 Reset mid-run abandons the run with no partial result retained; the first start after rst deasserts begins a full run from step 0.

Verification
REQ-030 Ideal D-latch model, default parameter, start pulse -> busy for 40 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
REQ-031 latch_q stuck at 0, latch_qn stuck at 1 -> done=1, pass=0, err_count=4 (steps 0,1,2,6), first_fail_step=0.
REQ-032 Transparent buffer model (q=d ignoring en, qn=~d) -> err_count=2 (steps 1,4), first_fail_step=1, pass=0.
REQ-033 Ideal latch with latch_qn tied equal to latch_q -> err_count=8, first_fail_step=0.
REQ-034 rst pulsed asynchronously (between clk edges) during step 3 -> all outputs at REQ-028 values before next clk edge; subsequent start with ideal model -> pass=1 after 40 cycles.
REQ-035 start re-pulsed at cycle 10 of a run, then SETTLE_CYCLES=5 run -> first run unaffected (done at cycle 40); second run done 64 cycles after its start.
